run_sequencer: RTL and testbench
================================

# run_sequencer

Host-side initiator for the core's `req`/`done` handshake. It loads operand bytes into data memory from an input stream, launches the program, and waits for `done` under a timeout. It then streams a result window back out of data memory. It sits outside the core and owns the data-memory port whenever the core is not running; the top level muxes `mem_*` against the core's own memory signals using `mem_sel`.

## Interface
- `AW`, 8, data-memory address width
- `CW`, 16, run-cycle counter width
- `TMO`, 4000, maximum RUN cycles before timeout (must be < 2^CW)

Ports:
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low; all state cleared while low
- `start`  in  1  begin a run; honoured only in IDLE
- `rd_base`  in  AW  first result address, latched on accepted `start`
- `rd_len`  in  AW  result word count, latched on accepted `start`
- `ld_valid`, `ld_addr[AW]`, `ld_data[8]`, `ld_last`  in  load stream
- `ld_ready`  out  1  load stream ready
- `core_req`  out  1  one-cycle launch pulse to core
- `core_done`  in  1  core finished (level, may be stale-high)
- `mem_sel`  out  1  1 = sequencer drives data memory
- `mem_wr_en`  out  1  data-memory write enable
- `mem_addr`  out  AW  data-memory address
- `mem_wdata`  out  8  data-memory write data
- `mem_rdata`  in  8  data-memory read data (combinational read)
- `res_valid`, `res_data[8]`, `res_last`  out  result stream
- `res_ready`  in  1  result stream ready
- `busy`  out  1  state != IDLE
- `fin`  out  1  one-cycle pulse on normal completion
- `timeout`  out  1  sticky; last run timed out
- `cycles`  out  CW  RUN-cycle count of last/current run

## Operation
- States: IDLE, LOAD, KICK, RUN, DUMP, FIN.
- IDLE: `mem_sel`=1, memory idle. On `start`:
  - latch `rd_base` and `rd_len`;
  - clear `timeout`;
  - go to LOAD.
- LOAD: `ld_ready`=1.
  - `mem_wr_en` = `ld_valid` (combinational), with `mem_addr`=`ld_addr` and `mem_wdata`=`ld_data`.
  - A handshake with `ld_last`=1 writes its byte, then goes to KICK.
  - Zero-length loads are not supported; at least one beat is required.
- KICK: `core_req`=1 for exactly one cycle; `cycles` cleared to 0 and `armed` cleared. Go to RUN.
- RUN: `mem_sel`=0; `cycles` increments every cycle.
  - `armed` sets the first cycle `core_done` is sampled low.
  - `core_done` is honoured only when `armed`=1.
  - Honoured `core_done` → DUMP.
  - `cycles`==TMO with no honoured done → set `timeout` and go to IDLE. No dump and no `fin` on this path.
  - If done and timeout occur on the same cycle, done wins.
- DUMP: `mem_sel`=1; index `idx` starts at 0.
  - `mem_addr` = `rd_base`+`idx` (mod 2^AW, wraps).
  - `res_valid`=1 and `res_data`=`mem_rdata`.
  - `res_last`=1 when `idx`==`rd_len`−1.
  - On `res_valid`&`res_ready`: `idx`++, and after the last word go to FIN.
  - `rd_len`=0 → go to FIN directly with no beats.
  - `res_data` must be stable while stalled.
- FIN: `fin`=1 for one cycle → IDLE.

## Timing
- Reset values: state IDLE; `mem_sel`=1; `core_req`, `mem_wr_en`, `ld_ready`, `res_valid`, `res_last`, `busy`, `fin`, `timeout`=0; `cycles`=0; `mem_addr`, `mem_wdata`=0.
- Reset asserted mid-run returns to IDLE asynchronously. `core_req` drops immediately and no `fin` is produced.
- `start` → LOAD next cycle; `busy` rises the same edge.
- Last load beat → KICK next cycle → `core_req` high one cycle → RUN.
- `cycles` reads 1 on the first RUN cycle and holds its final value after RUN until the next KICK.
- Load and result streams follow standard valid/ready rules: transfer on both high, with no combinational path from `res_ready` to `res_valid`.
- `start` outside IDLE is ignored.

## Test plan
- Load 4 bytes (addr 0..3 = 0x11,0x22,0x33,0x44, last on 4th), core model raises `core_done` 10 cycles after `core_req` → `core_req` high exactly 1 cycle, `cycles`=10, DUMP `rd_base`=0/`rd_len`=4 returns 0x11,0x22,0x33,0x44 with `res_last` on 4th, `fin` pulses once.
- `core_done` held high before and during KICK, low 1 cycle in RUN, then high → no early exit; DUMP entered only after the low-then-high sequence.
- Core never asserts done, TMO=20 → `timeout`=1 after 20 RUN cycles, `cycles`=20, state IDLE, no `res_valid`, no `fin`; next `start` clears `timeout`.
- `rd_base`=0xFE, `rd_len`=3, with `res_ready` toggling 1/0 → addresses 0xFE,0xFF,0x00; `res_data` stable while stalled; 3 beats delivered.
- `rd_len`=0 → FIN immediately after done, zero result beats, `fin`=1.
- `reset` dropped during RUN → all outputs at reset values within the same cycle; a following `start` runs normally.

Source files
------------

// File: rtl/run_sequencer_if.sv
// run_sequencer_if: start/load/core/memory/result signal bundle between the run sequencer and its host side.
interface run_sequencer_if #(parameter int AW = 8, parameter int CW = 16);
  logic start, ld_valid, ld_ready, ld_last, core_req, core_done;
  logic mem_sel, mem_wr_en, res_valid, res_ready, res_last, busy, fin, timeout;
  logic [AW-1:0] rd_base, rd_len, ld_addr, mem_addr;
  logic [7:0] ld_data, mem_wdata, mem_rdata, res_data;
  logic [CW-1:0] cycles;
  modport master (
    input start, rd_base, rd_len, ld_valid, ld_addr, ld_data, ld_last, core_done, mem_rdata, res_ready,
    output ld_ready, core_req, mem_sel, mem_wr_en, mem_addr, mem_wdata, res_valid, res_data, res_last,
    busy, fin, timeout, cycles
  );
  modport slave (
    output start, rd_base, rd_len, ld_valid, ld_addr, ld_data, ld_last, core_done, mem_rdata, res_ready,
    input ld_ready, core_req, mem_sel, mem_wr_en, mem_addr, mem_wdata, res_valid, res_data, res_last,
    busy, fin, timeout, cycles
  );
endinterface

// File: rtl/run_sequencer.sv
// run_sequencer: loads operands into data memory, launches the core, waits for done under a timeout,
// then streams a result window back out of data memory.
module run_sequencer #(parameter int AW = 8, parameter int CW = 16, parameter int TMO = 4000) (
  input logic clk,
  input logic reset,
  run_sequencer_if.master bus
);
  typedef enum logic [2:0] {IDLE, LOAD, KICK, RUN, DUMP, FIN} state_t;
  state_t state, next;
  logic [AW-1:0] base, len, idx;
  logic [CW-1:0] cycles;
  logic armed, timeout, done_ok, tmo_hit, ld_fire, res_fire;
  // a done level left high from a previous run is ignored until it has been seen low once
  assign done_ok = armed && bus.core_done;
  assign tmo_hit = cycles == CW'(TMO);
  assign ld_fire = state == LOAD && bus.ld_valid;
  assign res_fire = state == DUMP && bus.res_ready;
  always_comb begin
    next = state;
    case (state)
      IDLE: next = bus.start ? LOAD : IDLE;
      LOAD: next = ld_fire && bus.ld_last ? KICK : LOAD;
      KICK: next = RUN;
      RUN: next = done_ok ? (len == '0 ? FIN : DUMP) : tmo_hit ? IDLE : RUN;
      DUMP: next = res_fire && bus.res_last ? FIN : DUMP;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= next;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      base <= '0;
      len <= '0;
      idx <= '0;
      cycles <= '0;
      armed <= 1'b0;
      timeout <= 1'b0;
    end else begin
      if (state == IDLE && bus.start) begin
        base <= bus.rd_base;
        len <= bus.rd_len;
        timeout <= 1'b0;
      end
      if (next == KICK) begin
        cycles <= '0;
        armed <= 1'b0;
      end
      if (next == RUN) cycles <= cycles + 1'b1;
      if (state == RUN && !bus.core_done) armed <= 1'b1;
      if (state == RUN && next == IDLE) timeout <= 1'b1;
      idx <= state == DUMP ? idx + AW'(res_fire) : '0;
    end
  end
  assign bus.ld_ready = state == LOAD;
  assign bus.mem_wr_en = ld_fire;
  assign bus.mem_addr = state == LOAD ? bus.ld_addr : state == DUMP ? base + idx : '0;
  assign bus.mem_wdata = state == LOAD ? bus.ld_data : '0;
  assign bus.mem_sel = state != RUN;
  assign bus.core_req = state == KICK;
  assign bus.res_valid = state == DUMP;
  assign bus.res_data = state == DUMP ? bus.mem_rdata : '0;
  assign bus.res_last = state == DUMP && idx == len - 1'b1;
  assign bus.busy = state != IDLE;
  assign bus.fin = state == FIN;
  assign bus.timeout = timeout;
  assign bus.cycles = cycles;
endmodule

// File: tb/tb_run_sequencer.sv
// tb_run_sequencer: table rows plus random runs against a done/timeout model and a shadow memory.
module tb_run_sequencer;
  localparam int TMO = 20;
  typedef struct {
    logic [7:0] la;
    int ln;
    logic [7:0] base, len;
    int lf, hi, rm, ec;
    bit to;
  } vec_t;
  logic clk = 1'b0, reset = 1'b0;
  int n_chk = 0, n_fail = 0;
  logic [7:0] mem [256] = '{default: 8'h00};
  logic [7:0] ref_mem [256] = '{default: 8'h00};
  vec_t tbl [9];
  run_sequencer_if #(.AW(8), .CW(16)) bus ();
  run_sequencer #(.AW(8), .CW(16), .TMO(TMO)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  assign bus.mem_rdata = mem[bus.mem_addr];
  always @(posedge clk) if (bus.mem_sel && bus.mem_wr_en) mem[bus.mem_addr] <= bus.mem_wdata;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask
  task automatic chk_rst(input string nm);
    chk({nm, "_flags"}, 32'({bus.busy, bus.mem_sel, bus.core_req, bus.mem_wr_en, bus.ld_ready,
                           bus.res_valid, bus.res_last, bus.fin, bus.timeout}), 32'h080);
    chk({nm, "_cycles"}, 32'(bus.cycles), 32'h0);
    chk({nm, "_mem"}, 32'({bus.mem_addr, bus.mem_wdata}), 32'h0);
  endtask
  // core_done level during RUN cycle k: high before cycle lf (stale), high again from cycle hi
  function automatic bit dn(input int k, input int lf, input int hi);
    return k < lf || (hi != 0 && k >= hi);
  endfunction
  function automatic void model(input int lf, input int hi, output int c, output bit to);
    bit seen_low = 0;
    for (int k = 1; k <= TMO; k++) begin
      if (dn(k, lf, hi) && seen_low) begin
        c = k;
        to = 0;
        return;
      end
      if (!dn(k, lf, hi)) seen_low = 1;
    end
    c = TMO;
    to = 1;
  endfunction
  task automatic run(input logic [7:0] la, input int ln, input logic [7:0] base, input logic [7:0] len,
                     input int lf, input int hi, input int rm, input int ec, input bit eto, input bit rd);
    logic [7:0] a, d, prev;
    int i, cnt;
    bit pv;
    @(negedge clk);
    bus.start = 1;
    bus.rd_base = base;
    bus.rd_len = len;
    bus.core_done = lf > 1;
    @(negedge clk);
    bus.rd_base = ~base;
    bus.rd_len = len + 8'd1;
    #1 chk("load_busy", 32'(bus.busy), 32'h1);
    chk("tmo_clear", 32'(bus.timeout), 32'h0);
    chk("ld_ready", 32'(bus.ld_ready), 32'h1);
    for (int j = 0; j < ln; j++) begin
      if (j > 0 && $urandom_range(3) == 0) begin
        bus.ld_valid = 0;
        #1 chk("ld_gap", 32'(bus.mem_wr_en), 32'h0);
        @(negedge clk);
      end
      a = la + 8'(j);
      d = rd ? 8'($urandom) : {a[3:0] + 4'd1, a[3:0] + 4'd1};
      bus.ld_valid = 1;
      bus.ld_addr = a;
      bus.ld_data = d;
      bus.ld_last = j == ln - 1;
      ref_mem[a] = d;
      #1 chk("ld_write", 32'({bus.mem_wr_en, bus.mem_addr, bus.mem_wdata}), 32'({1'b1, a, d}));
      @(negedge clk);
      bus.start = 0;
      bus.rd_base = base;
      bus.rd_len = len;
    end
    bus.ld_valid = 0;
    bus.ld_last = 0;
    #1 chk("kick_req", 32'({bus.core_req, bus.mem_sel}), 32'h3);
    chk("kick_cycles", 32'(bus.cycles), 32'h0);
    for (int k = 1; k <= ec; k++) begin
      @(negedge clk);
      bus.core_done = dn(k, lf, hi);
      #1 chk("run_state", 32'({bus.mem_sel, bus.core_req, bus.res_valid}), 32'h0);
      chk("run_cycles", 32'(bus.cycles), 32'(k));
    end
    if (eto) begin
      @(negedge clk);
      bus.core_done = 0;
      #1 chk("tmo_flags", 32'({bus.busy, bus.timeout, bus.res_valid, bus.fin}), 32'h4);
      chk("tmo_cycles", 32'(bus.cycles), 32'(ec));
      return;
    end
    i = 0;
    cnt = 0;
    pv = 0;
    prev = '0;
    while (i < int'(len) && cnt < 100) begin
      @(negedge clk);
      bus.core_done = 0;
      cnt++;
      bus.res_ready = rm == 0 ? 1'b1 : rm == 1 ? cnt[0] : 1'($urandom_range(1));
      #1 chk("res_valid", 32'(bus.res_valid), 32'h1);
      chk("res_addr", 32'(bus.mem_addr), 32'(8'(base + i[7:0])));
      chk("res_data", 32'(bus.res_data), 32'(ref_mem[8'(base + i[7:0])]));
      chk("res_last", 32'(bus.res_last), 32'(i == int'(len) - 1));
      if (pv) chk("res_hold", 32'(bus.res_data), 32'(prev));
      prev = bus.res_data;
      pv = !bus.res_ready;
      if (bus.res_ready) i++;
    end
    if (i < int'(len)) chk("dump_bound", 32'(i), 32'(len));
    @(negedge clk);
    bus.core_done = 0;
    bus.res_ready = 0;
    #1 chk("fin_pulse", 32'({bus.fin, bus.res_valid, bus.busy}), 32'h5);
    chk("fin_cycles", 32'(bus.cycles), 32'(ec));
    @(negedge clk);
    #1 chk("fin_done", 32'({bus.fin, bus.busy}), 32'h0);
  endtask
  initial begin
    int ec;
    bit to;
    logic [7:0] b;
    bus.start = 0; bus.rd_base = 0; bus.rd_len = 0;
    bus.ld_valid = 0; bus.ld_addr = 0; bus.ld_data = 0; bus.ld_last = 0;
    bus.core_done = 0; bus.res_ready = 0;
    tbl[0] = '{8'h00, 4, 8'h00, 8'd4, 1, 10, 0, 10, 0};
    tbl[1] = '{8'h08, 2, 8'h08, 8'd2, 3, 4, 0, 4, 0};
    tbl[2] = '{8'h20, 1, 8'h20, 8'd1, 1, 0, 0, TMO, 1};
    tbl[3] = '{8'hFE, 3, 8'hFE, 8'd3, 1, 5, 1, 5, 0};
    tbl[4] = '{8'h30, 2, 8'h30, 8'd0, 1, 6, 0, 6, 0};
    tbl[5] = '{8'h40, 1, 8'h40, 8'd2, 1, TMO, 2, TMO, 0};
    tbl[6] = '{8'h50, 1, 8'h50, 8'd1, 1, 1, 0, TMO, 1};
    tbl[7] = '{8'h60, 2, 8'h60, 8'd2, 2, 3, 1, 3, 0};
    tbl[8] = '{8'h70, 1, 8'h6F, 8'd3, 1, 2, 2, 2, 0};
    @(negedge clk);
    #1 chk_rst("reset");
    reset = 1;
    for (int r = 0; r < 9; r++)
      run(tbl[r].la, tbl[r].ln, tbl[r].base, tbl[r].len, tbl[r].lf, tbl[r].hi, tbl[r].rm, tbl[r].ec, tbl[r].to, 0);
    // reset dropped in the middle of RUN
    @(negedge clk);
    bus.start = 1;
    bus.rd_base = 8'h10;
    bus.rd_len = 8'd1;
    @(negedge clk);
    bus.start = 0;
    bus.ld_valid = 1;
    bus.ld_addr = 8'h10;
    bus.ld_data = 8'h5A;
    bus.ld_last = 1;
    ref_mem[8'h10] = 8'h5A;
    @(negedge clk);
    bus.ld_valid = 0;
    bus.ld_last = 0;
    repeat (4) @(negedge clk);
    #1 chk("pre_rst_cycles", 32'(bus.cycles), 32'd4);
    reset = 0;
    #1 chk_rst("mid_rst");
    @(negedge clk);
    reset = 1;
    run(8'h10, 1, 8'h10, 8'd1, 1, 3, 0, 3, 0, 0);
    for (int r = 0; r < 25; r++) begin
      int lf, hi;
      lf = $urandom_range(1, 3);
      hi = $urandom_range(3) == 0 ? 0 : $urandom_range(1, TMO + 4);
      model(lf, hi, ec, to);
      b = 8'($urandom);
      run(8'($urandom), $urandom_range(1, 5), b, 8'($urandom_range(0, 5)), lf, hi, 2, ec, to, 1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
